cordic_result_fifo: RTL and testbench

Output buffer directly downstream of the CORDIC output interface stage. It captures each 32-bit result word (`interface_out` / `valid_out_interface`) into a small FIFO and presents it to the host or bus side through a valid/ready handshake. The CORDIC pipeline has no backpressure, so this block absorbs bursts. It also flags, with sticky status, any words lost because the FIFO was full.

---
 rtl/cordic_result_fifo.sv | 115 +++++++++++
 tb/tb_cordic_result_fifo.sv | 225 ++++++++++++++++++++++
 2 files changed

// File: rtl/cordic_result_fifo.sv
// First-word-fall-through result buffer behind the CORDIC output stage.
// Absorbs bursts from the non-stallable pipeline and counts words lost while full.
module cordic_result_fifo #(
   parameter int DATA_WIDTH     = 32,
   parameter int DEPTH          = 8,
   parameter int ADDR_WIDTH     = 3,
   parameter int DROP_CNT_WIDTH = 8
) (
   input  logic                      clk,
   input  logic                      rst_n,
   input  logic [DATA_WIDTH-1:0]     in_data,
   input  logic                      in_valid,
   output logic [DATA_WIDTH-1:0]     out_data,
   output logic                      out_valid,
   input  logic                      out_ready,
   output logic [ADDR_WIDTH:0]       count,
   output logic                      full,
   output logic                      overflow,
   output logic [DROP_CNT_WIDTH-1:0] drop_count,
   input  logic                      clear_status,
   input  logic                      flush
);

   localparam logic [ADDR_WIDTH:0]       DEPTH_C  = DEPTH[ADDR_WIDTH:0];
   localparam logic [ADDR_WIDTH:0]       CNT_ONE  = {{ADDR_WIDTH{1'b0}}, 1'b1};
   localparam logic [ADDR_WIDTH-1:0]     PTR_ONE  = {{(ADDR_WIDTH-1){1'b0}}, 1'b1};
   localparam logic [DROP_CNT_WIDTH-1:0] DROP_ONE = {{(DROP_CNT_WIDTH-1){1'b0}}, 1'b1};
   localparam logic [DROP_CNT_WIDTH-1:0] DROP_MAX = '1;

   logic [DATA_WIDTH-1:0]     mem_q [DEPTH];
   logic [ADDR_WIDTH-1:0]     rd_ptr_q, rd_ptr_d;
   logic [ADDR_WIDTH-1:0]     wr_ptr_q, wr_ptr_d;
   logic [ADDR_WIDTH:0]       count_q, count_d;
   logic                      overflow_q, overflow_d;
   logic [DROP_CNT_WIDTH-1:0] drop_count_q, drop_count_d;

   logic full_w;
   logic pop_raw;
   logic pop_en;
   logic push_en;
   logic drop_en;

   assign full_w    = (count_q == DEPTH_C);
   assign out_valid = (count_q != '0);
   assign out_data  = mem_q[rd_ptr_q];
   assign count     = count_q;
   assign full      = full_w;
   assign overflow  = overflow_q;
   assign drop_count = drop_count_q;

   // A pop in the same cycle frees a slot, so a full FIFO still accepts a push.
   always_comb begin
      pop_raw = out_valid & out_ready;
      pop_en  = pop_raw & ~flush;
      push_en = in_valid & ~flush & (~full_w | pop_raw);
      drop_en = in_valid & ~flush & full_w & ~pop_raw;
   end

   always_comb begin
      rd_ptr_d = rd_ptr_q;
      wr_ptr_d = wr_ptr_q;
      count_d  = count_q;
      if (flush) begin
         rd_ptr_d = '0;
         wr_ptr_d = '0;
         count_d  = '0;
      end else begin
         if (pop_en)  rd_ptr_d = rd_ptr_q + PTR_ONE;
         if (push_en) wr_ptr_d = wr_ptr_q + PTR_ONE;
         case ({push_en, pop_en})
            2'b10:   count_d = count_q + CNT_ONE;
            2'b01:   count_d = count_q - CNT_ONE;
            default: count_d = count_q;
         endcase
      end
   end

   // A drop coinciding with clear_status leaves one freshly recorded drop.
   always_comb begin
      overflow_d   = overflow_q;
      drop_count_d = drop_count_q;
      if (drop_en) begin
         overflow_d = 1'b1;
         if (clear_status)
            drop_count_d = DROP_ONE;
         else if (drop_count_q != DROP_MAX)
            drop_count_d = drop_count_q + DROP_ONE;
      end else if (clear_status) begin
         overflow_d   = 1'b0;
         drop_count_d = '0;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rd_ptr_q     <= '0;
         wr_ptr_q     <= '0;
         count_q      <= '0;
         overflow_q   <= 1'b0;
         drop_count_q <= '0;
      end else begin
         rd_ptr_q     <= rd_ptr_d;
         wr_ptr_q     <= wr_ptr_d;
         count_q      <= count_d;
         overflow_q   <= overflow_d;
         drop_count_q <= drop_count_d;
      end
   end

   // Storage is deliberately not reset; only occupancy decides what is valid.
   always_ff @(posedge clk) begin
      if (push_en) mem_q[wr_ptr_q] <= in_data;
   end

endmodule

// File: tb/tb_cordic_result_fifo.sv
// Scoreboard bench for cordic_result_fifo: queue-based reference model updated on
// the rising edge, independent monitor checking outputs on the falling edge.
module tb_cordic_result_fifo;

   localparam int DW    = 32;
   localparam int DEPTH = 8;
   localparam int AW    = 3;
   localparam int CW    = 8;

   logic          clk = 1'b0;
   logic          rst_n;
   logic [DW-1:0] in_data;
   logic          in_valid;
   logic [DW-1:0] out_data;
   logic          out_valid;
   logic          out_ready;
   logic [AW:0]   count;
   logic          full;
   logic          overflow;
   logic [CW-1:0] drop_count;
   logic          clear_status;
   logic          flush;

   cordic_result_fifo #(
      .DATA_WIDTH(DW), .DEPTH(DEPTH), .ADDR_WIDTH(AW), .DROP_CNT_WIDTH(CW)
   ) dut (
      .clk(clk), .rst_n(rst_n), .in_data(in_data), .in_valid(in_valid),
      .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
      .count(count), .full(full), .overflow(overflow), .drop_count(drop_count),
      .clear_status(clear_status), .flush(flush)
   );

   always #5 clk = ~clk;

   int n_checks = 0;
   int n_errors = 0;

   // reference model state
   logic [DW-1:0] exp_q[$];
   int            m_count = 0;
   bit            m_ovf   = 0;
   int            m_drops = 0;
   int            m_drops_total = 0;
   int            n_popped = 0;
   logic [DW-1:0] last_read = '0;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         m_count = 0;
         m_ovf   = 0;
         m_drops = 0;
         exp_q.delete();
      end else if (flush) begin
         m_count = 0;
         exp_q.delete();
         if (clear_status) begin
            m_ovf   = 0;
            m_drops = 0;
         end
      end else begin
         bit pop, push, drop;
         pop  = (m_count > 0) && out_ready;
         push = in_valid && ((m_count < DEPTH) || pop);
         drop = in_valid && !push;
         if (pop)  m_count--;
         if (push) begin
            exp_q.push_back(in_data);
            m_count++;
         end
         if (drop) begin
            m_drops_total++;
            m_ovf = 1;
            if (clear_status)    m_drops = 1;
            else if (m_drops < 255) m_drops++;
         end else if (clear_status) begin
            m_ovf   = 0;
            m_drops = 0;
         end
      end
   end

   always @(negedge clk) begin
      if (rst_n === 1'b1) begin
         chk("count",      64'(count),      64'(m_count));
         chk("out_valid",  64'(out_valid),  64'(m_count > 0));
         chk("full",       64'(full),       64'(m_count == DEPTH));
         chk("overflow",   64'(overflow),   64'(m_ovf));
         chk("drop_count", 64'(drop_count), 64'(m_drops));
         if (out_valid && out_ready && !flush) begin
            if (exp_q.size() == 0) begin
               chk("pop_with_empty_scoreboard", 64'(1), 64'(0));
            end else begin
               logic [DW-1:0] e;
               e = exp_q.pop_front();
               chk("out_data", 64'(out_data), 64'(e));
               last_read = out_data;
               n_popped++;
            end
         end
      end
   end

   task automatic cyc(input logic iv, input logic [DW-1:0] d, input logic rdy,
                      input logic fl, input logic cs);
      in_valid = iv; in_data = d; out_ready = rdy; flush = fl; clear_status = cs;
      @(posedge clk); #1;
   endtask

   task automatic drain();
      for (int i = 0; i < 40; i++) begin
         if (count == 0) break;
         cyc(1'b0, '0, 1'b1, 1'b0, 1'b0);
      end
      chk("drain_done", 64'(count), 64'(0));
      chk("drain_valid_low", 64'(out_valid), 64'(0));
      cyc(1'b0, '0, 1'b0, 1'b0, 1'b0);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int issued, popped0, drops0;
      rst_n = 1'b0;
      in_valid = 0; in_data = '0; out_ready = 0; flush = 0; clear_status = 0;
      #1;
      chk("rst_count", 64'(count), 64'(0));
      chk("rst_valid", 64'(out_valid), 64'(0));
      repeat (2) @(posedge clk);
      @(negedge clk);
      rst_n = 1'b1;
      @(posedge clk); #1;

      // ordered burst, then drain
      cyc(1'b1, 32'h00010002, 1'b0, 1'b0, 1'b0);
      chk("latency_valid", 64'(out_valid), 64'(1));
      chk("latency_data", 64'(out_data), 64'h00010002);
      cyc(1'b1, 32'h00030004, 1'b0, 1'b0, 1'b0);
      cyc(1'b1, 32'h0000ABCD, 1'b0, 1'b0, 1'b0);
      cyc(1'b0, '0, 1'b0, 1'b0, 1'b0);
      chk("burst_count", 64'(count), 64'(3));
      chk("stable_head", 64'(out_data), 64'h00010002);
      drain();
      chk("burst_last", 64'(last_read), 64'h0000ABCD);

      // overfill by two
      for (int i = 0; i < 10; i++) cyc(1'b1, DW'(i), 1'b0, 1'b0, 1'b0);
      cyc(1'b0, '0, 1'b0, 1'b0, 1'b0);
      chk("ovf_full", 64'(full), 64'(1));
      chk("ovf_flag", 64'(overflow), 64'(1));
      chk("ovf_drops", 64'(drop_count), 64'(2));
      drain();
      chk("ovf_last", 64'(last_read), 64'(7));
      cyc(1'b0, '0, 1'b0, 1'b0, 1'b1);
      chk("clear_flag", 64'(overflow), 64'(0));
      chk("clear_drops", 64'(drop_count), 64'(0));

      // push into full FIFO with simultaneous pop
      for (int i = 0; i < 8; i++) cyc(1'b1, 32'h100 + DW'(i), 1'b0, 1'b0, 1'b0);
      cyc(1'b1, 32'h55, 1'b1, 1'b0, 1'b0);
      chk("fullpop_count", 64'(count), 64'(8));
      chk("fullpop_drops", 64'(drop_count), 64'(0));
      drain();
      chk("fullpop_last", 64'(last_read), 64'h55);

      // random push stream with random backpressure
      popped0 = n_popped; drops0 = m_drops_total; issued = 0;
      for (int i = 0; i < 50; i++) begin
         cyc(1'b1, $urandom, 1'($urandom_range(0, 1)), 1'b0, 1'b0);
         issued++;
      end
      drain();
      chk("rand_conservation", 64'(n_popped - popped0), 64'(issued - (m_drops_total - drops0)));

      // flush with simultaneous push keeps status
      for (int i = 0; i < 5; i++) cyc(1'b1, 32'hF00 + DW'(i), 1'b0, 1'b0, 1'b0);
      cyc(1'b1, 32'hDEAD, 1'b0, 1'b1, 1'b0);
      chk("flush_count", 64'(count), 64'(0));
      chk("flush_valid", 64'(out_valid), 64'(0));
      chk("flush_drops", 64'(drop_count), 64'(m_drops));

      // clear_status coinciding with a drop
      for (int i = 0; i < 8; i++) cyc(1'b1, 32'hA0 + DW'(i), 1'b0, 1'b0, 1'b0);
      cyc(1'b1, 32'hBAD, 1'b0, 1'b0, 1'b1);
      chk("setwins_flag", 64'(overflow), 64'(1));
      chk("setwins_drops", 64'(drop_count), 64'(1));
      drain();

      // asynchronous reset mid-burst, overflow still set from above
      for (int i = 0; i < 4; i++) cyc(1'b1, 32'hC0 + DW'(i), 1'b0, 1'b0, 1'b0);
      in_valid = 1'b1; in_data = 32'hC4;
      #2;
      rst_n = 1'b0;
      #1;
      chk("arst_count", 64'(count), 64'(0));
      chk("arst_valid", 64'(out_valid), 64'(0));
      chk("arst_full", 64'(full), 64'(0));
      chk("arst_ovf", 64'(overflow), 64'(0));
      chk("arst_drops", 64'(drop_count), 64'(0));
      in_valid = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;
      @(posedge clk); #1;
      cyc(1'b1, 32'hCAFEF00D, 1'b0, 1'b0, 1'b0);
      chk("post_rst_data", 64'(out_data), 64'hCAFEF00D);
      drain();
      chk("post_rst_last", 64'(last_read), 64'hCAFEF00D);
      chk("sb_empty", 64'(exp_q.size()), 64'(0));

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
